// File: rtl/tc_si_to_nt_reg_pkg.sv
// ---------------------------------------------------------------------------
// tc_si_to_nt_reg_pkg
// Shared definitions for the single-initiator to NT-target Wishbone
// interconnect: FSM state encodings and default bus widths.
// No ports.
// ---------------------------------------------------------------------------
package tc_si_to_nt_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

endpackage

// File: rtl/tc_si_to_nt_reg_addr_dec.sv
// ---------------------------------------------------------------------------
// tc_addr_dec
// Combinational priority decoder. Compares the decoded top address bits
// against each target base; a disabled target never matches. When several
// targets match, the lowest index wins, so o_match is always one-hot or zero.
// Ports:
//   i_adr_top  in   DECW     top DECW bits of the initiator address
//   i_base     in   NT*DECW  packed bases, slice k = base of target k
//   i_en       in   NT       per-target enable
//   o_match    out  NT       one-hot match vector
//   o_hit      out  1        any enabled target matched
// ---------------------------------------------------------------------------
module tc_addr_dec #(
    parameter int NT   = 8,
    parameter int DECW = 3
) (
    input  logic [DECW-1:0]    i_adr_top,
    input  logic [NT*DECW-1:0] i_base,
    input  logic [NT-1:0]      i_en,
    output logic [NT-1:0]      o_match,
    output logic               o_hit
);

    always_comb begin
        o_match = '0;
        o_hit   = 1'b0;
        for (int k = 0; k < NT; k++) begin
            if (!o_hit && i_en[k] && (i_adr_top == i_base[k*DECW +: DECW])) begin
                o_match[k] = 1'b1;
                o_hit      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tc_si_to_nt_reg.sv
// ---------------------------------------------------------------------------
// tc_si_to_nt_reg
// Single-initiator to NT-target Wishbone classic interconnect. The target is
// decoded and latched in IDLE (one cycle of added latency) and held for the
// whole transfer; responses are taken only from the latched target. Unmapped
// addresses and targets that never answer are returned as a bus error.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for cyc&stb; decode address and latch sel_q
// BUSY  | latched target strobed; waiting for its ack/err or timeout
// ERR   | one registered error cycle to the initiator, targets idle
//
// Ports:
//   wb_clk_i, wb_rst_ni          clock, async active-low reset
//   i_wb_cyc/stb/adr/sel/we/dat_i  initiator request
//   i_wb_dat/ack/err_o           initiator response
//   t_wb_cyc/stb_o               per-target cycle/strobe (NT bits)
//   t_wb_adr/sel/we/dat_o        broadcast request to all targets
//   t_wb_dat/ack/err_i           per-target responses
//   tmo_o                        one-cycle pulse on timeout abort
//   err_adr_o                    address of the last errored transfer
// ---------------------------------------------------------------------------
module tc_si_to_nt_reg
    import tc_si_to_nt_reg_pkg::*;
#(
    parameter int              NT      = 8,
    parameter int              AW      = DEF_AW,
    parameter int              DW      = DEF_DW,
    parameter int              DECW    = 3,
    parameter logic [NT*DECW-1:0] T_BASE = 24'hFAC688,
    parameter logic [NT-1:0]   T_EN    = {NT{1'b1}},
    parameter int              TIMEOUT = 255
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic               i_wb_cyc_i,
    input  logic               i_wb_stb_i,
    input  logic [AW-1:0]      i_wb_adr_i,
    input  logic [DW/8-1:0]    i_wb_sel_i,
    input  logic               i_wb_we_i,
    input  logic [DW-1:0]      i_wb_dat_i,
    output logic [DW-1:0]      i_wb_dat_o,
    output logic               i_wb_ack_o,
    output logic               i_wb_err_o,
    output logic [NT-1:0]      t_wb_cyc_o,
    output logic [NT-1:0]      t_wb_stb_o,
    output logic [AW-1:0]      t_wb_adr_o,
    output logic [DW/8-1:0]    t_wb_sel_o,
    output logic               t_wb_we_o,
    output logic [DW-1:0]      t_wb_dat_o,
    input  logic [NT*DW-1:0]   t_wb_dat_i,
    input  logic [NT-1:0]      t_wb_ack_i,
    input  logic [NT-1:0]      t_wb_err_i,
    output logic               tmo_o,
    output logic [AW-1:0]      err_adr_o
);

    // A zero TIMEOUT would give a zero-width timer; keep one bit instead.
    localparam int           TW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [NT-1:0]   r_sel_q;
    logic [TW-1:0]   r_timer;
    logic [AW-1:0]   r_err_adr;
    logic            r_tmo;

    logic [NT-1:0]   w_match;
    logic            w_hit;
    logic            w_req;
    logic            w_ack_sel;
    logic            w_err_sel;
    logic            w_timeout;
    logic            w_sel_load;
    logic            w_err_cap;
    logic            w_tmo_set;
    logic [DW-1:0]   w_dat_sel;

    tc_addr_dec #(
        .NT   (NT),
        .DECW (DECW)
    ) u_dec (
        .i_adr_top (i_wb_adr_i[AW-1 -: DECW]),
        .i_base    (T_BASE),
        .i_en      (T_EN),
        .o_match   (w_match),
        .o_hit     (w_hit)
    );

    assign w_req     = i_wb_cyc_i & i_wb_stb_i;
    assign w_ack_sel = |(t_wb_ack_i & r_sel_q);
    assign w_err_sel = |(t_wb_err_i & r_sel_q);
    assign w_timeout = (TIMEOUT != 0) && (r_timer == TMO_LAST);

    // sel_q is one-hot, so OR-ing the masked slices is a plain mux.
    always_comb begin
        w_dat_sel = '0;
        for (int k = 0; k < NT; k++) begin
            if (r_sel_q[k]) begin
                w_dat_sel = w_dat_sel | t_wb_dat_i[k*DW +: DW];
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_load  = 1'b0;
        w_err_cap   = 1'b0;
        w_tmo_set   = 1'b0;
        t_wb_cyc_o  = '0;
        t_wb_stb_o  = '0;
        i_wb_ack_o  = 1'b0;
        i_wb_err_o  = 1'b0;
        i_wb_dat_o  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_sel_load = 1'b1;
                    if (w_hit) begin
                        w_state_nxt = ST_BUSY;
                    end else begin
                        w_state_nxt = ST_ERR;
                        w_err_cap   = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                t_wb_cyc_o = r_sel_q & {NT{i_wb_cyc_i}};
                t_wb_stb_o = r_sel_q & {NT{w_req}};
                i_wb_dat_o = w_dat_sel;
                // An abandoned cycle returns to IDLE silently, even if the
                // target answers in the same cycle.
                if (!i_wb_cyc_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_ack_sel) begin
                    i_wb_ack_o  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_err_sel) begin
                    i_wb_err_o  = 1'b1;
                    w_err_cap   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_timeout) begin
                    w_tmo_set   = 1'b1;
                    w_err_cap   = 1'b1;
                    w_state_nxt = ST_ERR;
                end
            end
            ST_ERR: begin
                i_wb_err_o  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_sel_q   <= '0;
            r_timer   <= '0;
            r_err_adr <= '0;
            r_tmo     <= 1'b0;
        end else begin
            if (w_sel_load) begin
                r_sel_q <= w_match;
            end
            // Counts only cycles spent waiting in BUSY; any exit clears it,
            // so every new transfer starts from zero.
            if ((r_state == ST_BUSY) && (w_state_nxt == ST_BUSY)) begin
                r_timer <= r_timer + 1'b1;
            end else begin
                r_timer <= '0;
            end
            if (w_err_cap) begin
                r_err_adr <= i_wb_adr_i;
            end
            r_tmo <= w_tmo_set;
        end
    end

    assign t_wb_adr_o = i_wb_adr_i;
    assign t_wb_sel_o = i_wb_sel_i;
    assign t_wb_we_o  = i_wb_we_i;
    assign t_wb_dat_o = i_wb_dat_i;
    assign tmo_o      = r_tmo;
    assign err_adr_o  = r_err_adr;

endmodule

// File: tb/tb_tc_si_to_nt_reg.sv
// ---------------------------------------------------------------------------
// tb_tc_si_to_nt_reg
// Directed bench for tc_si_to_nt_reg. Configuration: 8 targets, target 5
// disabled, target 6 base aliased onto target 1 (lowest index must win),
// TIMEOUT = 4.
// ---------------------------------------------------------------------------
module tb_tc_si_to_nt_reg;

    localparam int NT = 8;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk;
    logic            rst_n;
    logic            cyc, stb, we;
    logic [AW-1:0]   adr;
    logic [3:0]      sel;
    logic [DW-1:0]   wdat;
    logic [DW-1:0]   rdat;
    logic            ack, err;
    logic [NT-1:0]   t_cyc, t_stb;
    logic [AW-1:0]   t_adr;
    logic [3:0]      t_sel;
    logic            t_we;
    logic [DW-1:0]   t_wdat;
    logic [NT*DW-1:0] t_rdat;
    logic [NT-1:0]   t_ack, t_err;
    logic            tmo;
    logic [AW-1:0]   err_adr;

    int vectors;
    int miscompares;

    // bases (7..0) = 7,1,5,4,3,2,1,0
    tc_si_to_nt_reg #(
        .NT      (NT),
        .AW      (AW),
        .DW      (DW),
        .DECW    (3),
        .T_BASE  (24'hE6C688),
        .T_EN    (8'hDF),
        .TIMEOUT (4)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .i_wb_cyc_i (cyc),
        .i_wb_stb_i (stb),
        .i_wb_adr_i (adr),
        .i_wb_sel_i (sel),
        .i_wb_we_i  (we),
        .i_wb_dat_i (wdat),
        .i_wb_dat_o (rdat),
        .i_wb_ack_o (ack),
        .i_wb_err_o (err),
        .t_wb_cyc_o (t_cyc),
        .t_wb_stb_o (t_stb),
        .t_wb_adr_o (t_adr),
        .t_wb_sel_o (t_sel),
        .t_wb_we_o  (t_we),
        .t_wb_dat_o (t_wdat),
        .t_wb_dat_i (t_rdat),
        .t_wb_ack_i (t_ack),
        .t_wb_err_i (t_err),
        .tmo_o      (tmo),
        .err_adr_o  (err_adr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [AW-1:0] a);
        adr = a;
        cyc = 1'b1;
        stb = 1'b1;
    endtask

    task automatic idle_bus();
        cyc   = 1'b0;
        stb   = 1'b0;
        t_ack = '0;
        t_err = '0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = '0; sel = 4'hF; wdat = 32'h1234_5678;
        t_ack = '0; t_err = '0;
        for (int k = 0; k < NT; k++) t_rdat[k*DW +: DW] = 32'hDEAD_0000 + 32'(k);
        t_rdat[2*DW +: DW] = 32'hCAFE_F00D;
        t_rdat[1*DW +: DW] = 32'h1111_2222;

        // reset state
        #3;
        check("rst_t_cyc",   64'(t_cyc),   64'h0);
        check("rst_ack",     64'(ack),     64'h0);
        check("rst_err",     64'(err),     64'h0);
        check("rst_dat",     64'(rdat),    64'h0);
        check("rst_tmo",     64'(tmo),     64'h0);
        check("rst_err_adr", 64'(err_adr), 64'h0);
        #8 rst_n = 1'b1;

        // 1: read target 2, acked on the 2nd BUSY cycle, cyc held -> back-to-back
        tick();
        req(32'h4000_0010);
        #1;
        check("t1_idle_stb", 64'(t_stb), 64'h0);
        check("t1_bcast_adr", 64'(t_adr), 64'h4000_0010);
        tick();
        #1;
        check("t1_busy1_stb", 64'(t_stb), 64'h04);
        check("t1_busy1_ack", 64'(ack),   64'h0);
        check("t1_busy1_dat", 64'(rdat),  64'hCAFE_F00D);
        tick();
        t_ack[2] = 1'b1;
        #1;
        check("t1_busy2_ack", 64'(ack),  64'h1);
        check("t1_busy2_dat", 64'(rdat), 64'hCAFE_F00D);
        check("t1_busy2_err", 64'(err),  64'h0);

        // 4: next transfer to 0x2..., targets 1 and 6 both match -> target 1
        tick();
        t_ack = '0;
        req(32'h2000_0000);
        #1;
        check("t4_idle_cyc", 64'(t_cyc), 64'h0);
        check("t4_idle_ack", 64'(ack),   64'h0);
        tick();
        t_ack[0] = 1'b1;
        #1;
        check("t4_prio_cyc",  64'(t_cyc), 64'h02);
        check("t4_spur_ack",  64'(ack),   64'h0);
        tick();
        t_ack[1] = 1'b1;
        t_err[1] = 1'b1;
        #1;
        check("t4_ackerr_ack", 64'(ack),  64'h1);
        check("t4_ackerr_err", 64'(err),  64'h0);
        check("t4_ackerr_dat", 64'(rdat), 64'h1111_2222);
        tick();
        idle_bus();
        #1;
        check("t4_after_ack", 64'(ack), 64'h0);
        check("t4_after_err_adr", 64'(err_adr), 64'h0);

        // target error path: target 3 errors, address captured
        req(32'h6000_0004);
        tick();
        t_err[3] = 1'b1;
        #1;
        check("te_busy_err", 64'(err), 64'h1);
        check("te_busy_ack", 64'(ack), 64'h0);
        tick();
        idle_bus();
        #1;
        check("te_err_adr", 64'(err_adr), 64'h6000_0004);
        check("te_idle_err", 64'(err), 64'h0);

        // 2: disabled target 5 -> decode miss
        req(32'hA000_0000);
        #1;
        check("t2_idle_cyc", 64'(t_cyc), 64'h0);
        tick();
        idle_bus();
        #1;
        check("t2_err_cyc",  64'(t_cyc),   64'h0);
        check("t2_err",      64'(err),     64'h1);
        check("t2_err_adr",  64'(err_adr), 64'hA000_0000);
        tick();
        #1;
        check("t2_err_once", 64'(err), 64'h0);

        // 3: target 0 never answers, TIMEOUT = 4
        req(32'h0000_0100);
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            check("t3_busy_cyc", 64'(t_cyc), 64'h01);
            check("t3_busy_tmo", 64'(tmo),   64'h0);
        end
        tick();
        #1;
        check("t3_abort_cyc", 64'(t_cyc),   64'h0);
        check("t3_tmo",       64'(tmo),     64'h1);
        check("t3_err",       64'(err),     64'h1);
        check("t3_err_adr",   64'(err_adr), 64'h0000_0100);
        idle_bus();
        tick();
        #1;
        check("t3_tmo_pulse", 64'(tmo), 64'h0);
        check("t3_err_once",  64'(err), 64'h0);

        // 5: initiator abandons BUSY while the target acks
        req(32'hE000_0000);
        tick();
        #1;
        check("t5_busy_cyc", 64'(t_cyc), 64'h80);
        cyc = 1'b0;
        stb = 1'b0;
        t_ack[7] = 1'b1;
        #1;
        check("t5_drop_cyc", 64'(t_cyc), 64'h0);
        check("t5_drop_ack", 64'(ack),   64'h0);
        check("t5_drop_err", 64'(err),   64'h0);
        tick();
        t_ack = '0;
        req(32'h8000_0000);
        #1;
        check("t5_idle_cyc", 64'(t_cyc), 64'h0);
        tick();
        #1;
        check("t5_redec_cyc", 64'(t_cyc), 64'h10);
        t_ack[4] = 1'b1;
        #1;
        check("t5_redec_ack", 64'(ack), 64'h1);
        tick();
        idle_bus();

        // 6: async reset mid-BUSY, then a normal transfer
        req(32'h6000_0000);
        tick();
        t_ack[3] = 1'b1;
        #1;
        check("t6_pre_ack", 64'(ack), 64'h1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_cyc",     64'(t_cyc),   64'h0);
        check("t6_rst_ack",     64'(ack),     64'h0);
        check("t6_rst_dat",     64'(rdat),    64'h0);
        check("t6_rst_err_adr", 64'(err_adr), 64'h0);
        t_ack = '0;
        #3 rst_n = 1'b1;
        tick();
        #1;
        check("t6_post_cyc", 64'(t_cyc), 64'h08);
        t_ack[3] = 1'b1;
        #1;
        check("t6_post_ack", 64'(ack), 64'h1);
        tick();
        idle_bus();
        #1;
        check("t6_final_cyc", 64'(t_cyc), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
